// File: rtl/counter_param_if.sv
// Control and status bundle for counter_param: the master drives enable, mode,
// load data and flag clear; the slave returns count, carry pulse and sticky flag.
interface counter_param_if #(
    parameter int WIDTH = 8
);
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] data;
    logic             clr_ovf;
    logic [WIDTH-1:0] Q;
    logic             rco;
    logic             ovf;

    modport master (
        output enb, modo, data, clr_ovf,
        input  Q, rco, ovf
    );

    modport slave (
        input  enb, modo, data, clr_ovf,
        output Q, rco, ovf
    );
endinterface

// File: rtl/counter_param.sv
// Parameterised up/down/step/load counter with optional saturation, a one-cycle
// boundary pulse (rco) and a sticky boundary flag (ovf). All outputs are registered.
module counter_param #(
    parameter int WIDTH = 8,
    parameter int STEP  = 3,
    parameter int SAT   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    counter_param_if.slave  bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_reg, q_next;
    logic             rco_reg, rco_next;
    logic             ovf_reg, ovf_next;

    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   sum_up;
    logic             boundary;

    // One extra bit so the carry-out marks an up-count boundary for any step size.
    assign inc    = (bus.modo == 2'b10) ? STEP_EXT : ONE_EXT;
    assign sum_up = {1'b0, q_reg} + inc;

    always_comb begin
        q_next   = q_reg;
        boundary = 1'b0;
        if (bus.enb) begin
            case (bus.modo)
                2'b00, 2'b10: begin
                    boundary = sum_up[WIDTH];
                    if (boundary && (SAT != 0))
                        q_next = ALL_ONES;
                    else
                        q_next = sum_up[WIDTH-1:0];
                end
                2'b01: begin
                    boundary = (q_reg == '0);
                    if (boundary && (SAT != 0))
                        q_next = '0;
                    else
                        q_next = q_reg - 1'b1;
                end
                default: begin
                    q_next = bus.data;
                end
            endcase
        end
        rco_next = boundary;
        // A boundary on the same edge as a clear must leave the flag set.
        ovf_next = boundary | (ovf_reg & ~bus.clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            rco_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            rco_reg <= rco_next;
            ovf_reg <= ovf_next;
        end
    end

    assign bus.Q   = q_reg;
    assign bus.rco = rco_reg;
    assign bus.ovf = ovf_reg;
endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: a wrapping and a saturating 4-bit instance share one
// directed stimulus stream and are checked every cycle against an arithmetic model.
module tb_counter_param;
    localparam int W    = 4;
    localparam int STEP = 3;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enb;
    logic [1:0]   modo;
    logic [W-1:0] data;
    logic         clr_ovf;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = wrapping instance, index 1 = saturating instance.
    int m_q[2];
    int m_rco[2];
    int m_ovf[2];

    // Hand-computed expectations handed from the stimulus to the compare process.
    int    lit_q[2];
    int    lit_rco[2];
    int    lit_ovf[2];
    string lit_tag[2];
    int    lit_seq[2];

    logic [W-1:0] dq[2];
    logic         drco[2];
    logic         dovf[2];

    counter_param_if #(.WIDTH(W)) bus0 ();
    counter_param_if #(.WIDTH(W)) bus1 ();

    assign bus0.enb = enb;  assign bus0.modo = modo;  assign bus0.data = data;  assign bus0.clr_ovf = clr_ovf;
    assign bus1.enb = enb;  assign bus1.modo = modo;  assign bus1.data = data;  assign bus1.clr_ovf = clr_ovf;

    assign dq[0] = bus0.Q;  assign drco[0] = bus0.rco;  assign dovf[0] = bus0.ovf;
    assign dq[1] = bus1.Q;  assign drco[1] = bus1.rco;  assign dovf[1] = bus1.ovf;

    counter_param #(.WIDTH(W), .STEP(STEP), .SAT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    counter_param #(.WIDTH(W), .STEP(STEP), .SAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Applies the counter rules to the model for the inputs present at this edge.
    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            int t;
            bit b;
            b = 1'b0;
            if (!rst_n) begin
                m_q[i] = 0; m_rco[i] = 0; m_ovf[i] = 0;
                continue;
            end
            if (enb) begin
                if (modo == 2'd0 || modo == 2'd2) begin
                    t = m_q[i] + ((modo == 2'd0) ? 1 : STEP);
                    if (t > MAXV) begin
                        b = 1'b1;
                        m_q[i] = (i == 1) ? MAXV : t - (MAXV + 1);
                    end else begin
                        m_q[i] = t;
                    end
                end else if (modo == 2'd1) begin
                    if (m_q[i] == 0) begin
                        b = 1'b1;
                        m_q[i] = (i == 1) ? 0 : MAXV;
                    end else begin
                        m_q[i] = m_q[i] - 1;
                    end
                end else begin
                    m_q[i] = int'(data);
                end
            end
            m_rco[i] = int'(b);
            m_ovf[i] = b ? 1 : (clr_ovf ? 0 : m_ovf[i]);
        end
    endfunction

    task automatic step(input bit e, input int m, input int d, input bit c);
        @(negedge clk);
        enb = e; modo = 2'(m); data = W'(d); clr_ovf = c;
        @(posedge clk);
        model_edge();
    endtask

    task automatic want(input int i, input string tag, input int q, input int r, input int o);
        lit_q[i] = q; lit_rco[i] = r; lit_ovf[i] = o; lit_tag[i] = tag;
        lit_seq[i] = lit_seq[i] + 1;
    endtask

    // Compare process: model vs DUT every cycle, plus any pending literal expectation.
    initial begin
        int seen_seq[2];
        seen_seq[0] = 0; seen_seq[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dq[i] !== W'(m_q[i]) || drco[i] !== 1'(m_rco[i]) || dovf[i] !== 1'(m_ovf[i])) begin
                    bad++;
                    $display("FAIL model_track dut%0d t=%0t: got Q=%0d rco=%0b ovf=%0b, want Q=%0d rco=%0d ovf=%0d",
                             i, $time, dq[i], drco[i], dovf[i], m_q[i], m_rco[i], m_ovf[i]);
                end
                if (lit_seq[i] != seen_seq[i]) begin
                    seen_seq[i] = lit_seq[i];
                    total++;
                    if (dq[i] !== W'(lit_q[i]) || drco[i] !== 1'(lit_rco[i]) || dovf[i] !== 1'(lit_ovf[i])) begin
                        bad++;
                        $display("FAIL %s dut%0d t=%0t: got Q=%0d rco=%0b ovf=%0b, want Q=%0d rco=%0d ovf=%0d",
                                 lit_tag[i], i, $time, dq[i], drco[i], dovf[i], lit_q[i], lit_rco[i], lit_ovf[i]);
                    end
                    total++;
                    if (m_q[i] != lit_q[i] || m_rco[i] != lit_rco[i] || m_ovf[i] != lit_ovf[i]) begin
                        bad++;
                        $display("FAIL model_pin_%s dut%0d: model Q=%0d rco=%0d ovf=%0d, want Q=%0d rco=%0d ovf=%0d",
                                 lit_tag[i], i, m_q[i], m_rco[i], m_ovf[i], lit_q[i], lit_rco[i], lit_ovf[i]);
                    end
                end
            end
        end
    end

    initial begin
        int up0[5];
        int up1[5];
        int dn0[3];
        int dn1[3];
        int rc0[3];
        int rc1[3];
        up0 = '{5, 8, 11, 14, 1};
        up1 = '{5, 8, 11, 14, 15};
        dn0 = '{0, 15, 14};
        dn1 = '{0, 0, 0};
        rc0 = '{0, 1, 0};
        rc1 = '{0, 1, 1};
        lit_seq[0] = 0; lit_seq[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_rco[i] = 0; m_ovf[i] = 0;
        end
        rst_n = 1'b0; enb = 1'b0; modo = 2'd0; data = '0; clr_ovf = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        want(0, "reset", 0, 0, 0);
        want(1, "reset", 0, 0, 0);

        // Up-count through the boundary.
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 0, 0, 1'b0);
            want(0, "wrap_up", k % 16, int'(k == 16), int'(k >= 16));
            want(1, "sat_up", (k < 16) ? k : 15, int'(k >= 16), int'(k >= 16));
        end

        // Load then step by STEP.
        step(1'b1, 3, 2, 1'b0);
        want(0, "load2", 2, 0, 1);
        want(1, "load2", 2, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2, 0, 1'b0);
            want(0, "step_up", up0[k], int'(k == 4), 1);
            want(1, "step_sat", up1[k], int'(k == 4), 1);
        end

        // Clear with enable low, then step exactly to and just past the boundary.
        step(1'b0, 0, 0, 1'b1);
        want(0, "clr_idle", 1, 0, 0);
        want(1, "clr_idle", 15, 0, 0);
        step(1'b1, 3, 12, 1'b0);
        step(1'b1, 2, 0, 1'b0);
        want(0, "step_to_max", 15, 0, 0);
        want(1, "step_to_max", 15, 0, 0);
        step(1'b1, 3, 13, 1'b0);
        step(1'b1, 2, 0, 1'b0);
        want(0, "step_carry", 0, 1, 1);
        want(1, "step_carry", 15, 1, 1);
        step(1'b0, 0, 0, 1'b1);
        want(0, "clr2", 0, 0, 0);
        want(1, "clr2", 15, 0, 0);

        // Enable gating.
        step(1'b1, 3, 4, 1'b0);
        step(1'b1, 0, 0, 1'b0);
        want(0, "pre_gate", 5, 0, 0);
        want(1, "pre_gate", 5, 0, 0);
        repeat (4) begin
            step(1'b0, 0, 0, 1'b0);
            want(0, "gate_hold", 5, 0, 0);
            want(1, "gate_hold", 5, 0, 0);
        end
        step(1'b1, 0, 0, 1'b0);
        want(0, "gate_resume", 6, 0, 0);
        want(1, "gate_resume", 6, 0, 0);

        // Down-count through zero.
        step(1'b1, 3, 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1, 0, 1'b0);
            want(0, "down_wrap", dn0[k], rc0[k], int'(k >= 1));
            want(1, "down_sat", dn1[k], rc1[k], int'(k >= 1));
        end

        // Set beats clear on the same edge; clear alone then wins.
        step(1'b0, 0, 0, 1'b1);
        want(0, "clr3", 14, 0, 0);
        want(1, "clr3", 0, 0, 0);
        step(1'b1, 3, 15, 1'b0);
        step(1'b1, 0, 0, 1'b1);
        want(0, "set_wins", 0, 1, 1);
        want(1, "set_wins", 15, 1, 1);
        step(1'b0, 0, 0, 1'b1);
        want(0, "clr_alone", 0, 0, 0);
        want(1, "clr_alone", 15, 0, 0);

        // Load keeps the flag, then asynchronous reset mid-cycle.
        step(1'b1, 3, 15, 1'b0);
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 3, 9, 1'b0);
        want(0, "load_keeps_ovf", 9, 0, 1);
        want(1, "load_keeps_ovf", 9, 0, 1);
        #3;
        rst_n = 1'b0;
        model_edge();
        want(0, "async_rst", 0, 0, 0);
        want(1, "async_rst", 0, 0, 0);
        repeat (3) begin
            step(1'b1, 0, 0, 1'b0);
            want(0, "rst_hold", 0, 0, 0);
            want(1, "rst_hold", 0, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        enb = 1'b0;
        step(1'b1, 0, 0, 1'b0);
        want(0, "post_rst", 1, 0, 0);
        want(1, "post_rst", 1, 0, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
